hazard_flag_unit: RTL and testbench
===================================

// Module: hazard_flag_unit
// PURPOSE
//  Pipeline companion to the decode/condition control path. It owns the NZVC flag register
//  that feeds the conditional unit (NE2/ZE2/VE2/CE2), and it consumes takeBranchE to redirect
//  fetch and flush the front end. It detects load-use hazards, holds the pipe for multi-cycle
//  loads, and arbitrates between branch flush and stall.
// PARAMETERS
//  OPCODEWIDTH  4  opcode width, matching the controller
//  REGWIDTH     4  register-index width
//  MEM_LAT      3  load latency in M stage, cycles (>=1; 1 = no wait)
// PORTS
//  clk               in   1    clock, rising edge
//  rstN              in   1    async reset, active-low
//  flagWriteE        in   1    instr in E updates flags (pipelined outFlag)
//  NE, ZE, VE, CE    in   1    ALU flags of instr in E
//  takeBranchE       in   1    branch taken, from conditional unit
//  loadE             in   1    instr in E is a load (resultSelectorWB=mem)
//  regDstE           in   REGW destination reg of instr in E
//  src1D, src2D      in   REGW source regs of instr in D
//  useSrc1D, useSrc2D in  1    instr in D reads src1D/src2D
//  NE2, ZE2, VE2, CE2 out 1    registered flags to conditional unit
//  pcSrcF            out  1    1 = select branch target at fetch
//  stallF, stallD    out  1    hold PC / IF-ID register
//  stallE, stallM    out  1    hold ID-EX / EX-MEM register
//  flushD, flushE    out  1    bubble IF-ID / ID-EX register
// BEHAVIOUR
//  Reset (rstN low, async): state=RUN, waitCnt=0, NE2..CE2=0. While rstN is low, all
//   stall/flush/pcSrcF outputs are forced to 0.
//  FSM states:
//   RUN:     if loadE && MEM_LAT>1 -> MEMWAIT at the edge; waitCnt<=MEM_LAT-1
//   MEMWAIT: stallF=stallD=stallE=stallM=1 and all other outputs 0; waitCnt-- each edge;
//            at waitCnt==1 -> RUN on that edge (exactly MEM_LAT-1 stall cycles)
//  A load-use hazard in RUN is defined as:
//   hazard = loadE && regDstE!=0 && ((useSrc1D && src1D==regDstE) || (useSrc2D && src2D==regDstE))
//  RUN outputs (combinational from inputs and state), in priority order:
//   1. takeBranchE=1:  pcSrcF=1, flushD=1, flushE=1, no stalls (load-use ignored)
//   2. hazard=1:       stallF=1, stallD=1, flushE=1 (one bubble)
//   3. otherwise:      all 0
//  Flag register: on each edge in RUN with flagWriteE=1, {NE2,ZE2,VE2,CE2} <= {NE,ZE,VE,CE}.
//   The register holds its value in MEMWAIT and when flagWriteE=0.
//   - A flag write and a taken branch in the same E cycle: the flag write still commits.
//   - takeBranchE during MEMWAIT is ignored. E is held, so the branch resolves on the first
//     RUN cycle after the wait.
//   - A load that is flushed by a branch in the same cycle still enters M and still triggers
//     MEMWAIT (conservative; loadE is sampled pre-flush).
//  Register 0 never causes a hazard. MEM_LAT=1: the unit never enters MEMWAIT.
//  Reset asserted mid-MEMWAIT: immediate return to RUN with waitCnt=0 and flags cleared.
// TESTING
//  1. Reset with rstN=0 and random inputs -> all outputs 0; release -> state RUN, flags 0.
//  2. flagWriteE=1, NZVC=1010 -> next cycle NE2..CE2=1010; then flagWriteE=0 with
//     NZVC=0101 -> flags stay 1010.
//  3. loadE=1, regDstE=3, useSrc1D=1, src1D=3 -> stallF=stallD=flushE=1 in that cycle;
//     with MEM_LAT=3, the next 2 cycles have stallF/D/E/M=1, then outputs return to 0.
//  4. takeBranchE=1 with the same load-use condition -> pcSrcF=flushD=flushE=1, stallF=0.
//  5. regDstE=0 and src1D=0 with loadE=1 -> no load-use stall (MEMWAIT still occurs).
//  6. rstN pulsed low at the second MEMWAIT cycle -> outputs 0 immediately; after release,
//     no residual stall.

Source files
------------

// File: rtl/hazard_flag_unit.sv
// Hazard/flag companion to the decode and condition path: owns the NZVC flag register,
// redirects fetch on taken branches, and stalls or bubbles the pipe for loads.
module hazard_flag_unit #(
  parameter int unsigned OPCODEWIDTH = 4,
  parameter int unsigned REGWIDTH    = 4,
  parameter int unsigned MEM_LAT     = 3
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                flagWriteE,
  input  logic                NE,
  input  logic                ZE,
  input  logic                VE,
  input  logic                CE,
  input  logic                takeBranchE,
  input  logic                loadE,
  input  logic [REGWIDTH-1:0] regDstE,
  input  logic [REGWIDTH-1:0] src1D,
  input  logic [REGWIDTH-1:0] src2D,
  input  logic                useSrc1D,
  input  logic                useSrc2D,
  output logic                NE2,
  output logic                ZE2,
  output logic                VE2,
  output logic                CE2,
  output logic                pcSrcF,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                stallM,
  output logic                flushD,
  output logic                flushE
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] WaitInit = CntW'(MEM_LAT - 1);

  if (MEM_LAT < 1 || OPCODEWIDTH < 1 || REGWIDTH < 1) begin : g_bad_param
    $error("hazard_flag_unit: MEM_LAT, OPCODEWIDTH and REGWIDTH must be >= 1");
  end

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]      flags_q, flags_d;
  logic            hazard_c;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign hazard_c = loadE && (regDstE != '0) &&
                    ((useSrc1D && (src1D == regDstE)) ||
                     (useSrc2D && (src2D == regDstE)));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      flags_q    <= flags_d;
    end
  end

  // Loads are sampled pre-flush, so a branch-killed load still waits out the memory.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    flags_d    = flags_q;
    case (state_q)
      RUN: begin
        if (flagWriteE) begin
          flags_d = {NE, ZE, VE, CE};
        end
        if (loadE && (MEM_LAT > 1)) begin
          state_d    = MEMWAIT;
          wait_cnt_d = WaitInit;
        end
      end
      MEMWAIT: begin
        wait_cnt_d = wait_cnt_q - CntW'(1);
        if (wait_cnt_q == CntW'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Branch redirect outranks the load-use bubble; everything is quiet while in reset.
  always_comb begin
    pcSrcF = 1'b0;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rstN) begin
      case (state_q)
        RUN: begin
          if (takeBranchE) begin
            pcSrcF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (hazard_c) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
        MEMWAIT: begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {NE2, ZE2, VE2, CE2} = flags_q;

endmodule

// File: tb/tb_hazard_flag_unit.sv
// Bench for hazard_flag_unit: directed vector table, hand-written reset sequences,
// and random traffic against a stall-budget reference model.
module tb_hazard_flag_unit;

  localparam int unsigned REGW    = 4;
  localparam int unsigned MEM_LAT = 3;

  localparam logic [6:0] CTL_IDLE = 7'b0000000;
  localparam logic [6:0] CTL_HAZ  = 7'b0110001;
  localparam logic [6:0] CTL_WAIT = 7'b0111100;
  localparam logic [6:0] CTL_BR   = 7'b1000011;

  logic            clk, rstN;
  logic            flagWriteE, NE, ZE, VE, CE, takeBranchE, loadE;
  logic [REGW-1:0] regDstE, src1D, src2D;
  logic            useSrc1D, useSrc2D;
  logic            NE2, ZE2, VE2, CE2;
  logic            pcSrcF, stallF, stallD, stallE, stallM, flushD, flushE;

  logic [6:0] ctl;
  logic [3:0] flags;
  assign ctl   = {pcSrcF, stallF, stallD, stallE, stallM, flushD, flushE};
  assign flags = {NE2, ZE2, VE2, CE2};

  hazard_flag_unit #(
    .OPCODEWIDTH(4),
    .REGWIDTH   (REGW),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .flagWriteE (flagWriteE),
    .NE         (NE),
    .ZE         (ZE),
    .VE         (VE),
    .CE         (CE),
    .takeBranchE(takeBranchE),
    .loadE      (loadE),
    .regDstE    (regDstE),
    .src1D      (src1D),
    .src2D      (src2D),
    .useSrc1D   (useSrc1D),
    .useSrc2D   (useSrc2D),
    .NE2        (NE2),
    .ZE2        (ZE2),
    .VE2        (VE2),
    .CE2        (CE2),
    .pcSrcF     (pcSrcF),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fw;
    logic [3:0] nzvc;
    logic       br;
    logic       ld;
    logic [3:0] dst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] exp_flags;
    logic [6:0] exp_ctl;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining stall cycles owed to the memory plus the architectural flags.
  int         stall_left = 0;
  logic [3:0] m_flags    = 4'b0000;

  function automatic logic [6:0] model_ctl();
    if (!rstN) return CTL_IDLE;
    if (stall_left > 0) return CTL_WAIT;
    if (takeBranchE) return CTL_BR;
    if (loadE && regDstE != 0 &&
        ((useSrc1D && src1D == regDstE) || (useSrc2D && src2D == regDstE)))
      return CTL_HAZ;
    return CTL_IDLE;
  endfunction

  task automatic model_advance();
    if (!rstN) begin
      stall_left = 0;
      m_flags    = 4'b0000;
    end else if (stall_left > 0) begin
      stall_left = stall_left - 1;
    end else begin
      if (flagWriteE) m_flags = {NE, ZE, VE, CE};
      if (loadE && MEM_LAT > 1) stall_left = int'(MEM_LAT) - 1;
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    flagWriteE  = v.fw;
    {NE, ZE, VE, CE} = v.nzvc;
    takeBranchE = v.br;
    loadE       = v.ld;
    regDstE     = v.dst;
    src1D       = v.s1;
    src2D       = v.s2;
    useSrc1D    = v.u1;
    useSrc2D    = v.u2;
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, CTL_IDLE};
    drive(v);
  endtask

  task automatic drive_random();
    flagWriteE  = 1'($urandom_range(0, 1));
    {NE, ZE, VE, CE} = 4'($urandom_range(0, 15));
    takeBranchE = ($urandom_range(0, 7) == 0);
    loadE       = ($urandom_range(0, 3) == 0);
    regDstE     = 4'($urandom_range(0, 3));
    src1D       = 4'($urandom_range(0, 3));
    src2D       = 4'($urandom_range(0, 3));
    useSrc1D    = 1'($urandom_range(0, 1));
    useSrc2D    = 1'($urandom_range(0, 1));
  endtask

  // Inputs are already applied just after a rising edge; sample mid-cycle, then move on.
  task automatic run_cycle(input string name, input logic [6:0] ectl, input logic [3:0] eflags);
    #2;
    check({name, "_ctl"}, ctl, ectl);
    check({name, "_flags"}, {3'b000, flags}, {3'b000, eflags});
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               fw  nzvc   br    ld    dst   s1    s2    u1    u2    flags  ctl
    vecs[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, CTL_IDLE};
    vecs[1]  = '{1'b0, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, CTL_IDLE};
    vecs[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, CTL_IDLE};
    vecs[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 4'hA, CTL_HAZ};
    vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, CTL_WAIT};
    vecs[5]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, CTL_WAIT};
    vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, CTL_IDLE};
    vecs[7]  = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 4'hA, CTL_BR};
    vecs[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h3, CTL_IDLE};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_IDLE};
    vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 4'h5, 4'h5, 1'b0, 1'b1, 4'h3, CTL_HAZ};
    vecs[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 4'h7, 4'h6, 1'b0, 1'b1, 4'h3, CTL_IDLE};
    vecs[18] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[19] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_WAIT};
    vecs[20] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, CTL_IDLE};

    // Reset held with random inputs: everything must stay quiet.
    rstN = 1'b0;
    drive_random();
    #1;
    for (int i = 0; i < 4; i++) begin
      drive_random();
      run_cycle($sformatf("reset%0d", i), CTL_IDLE, 4'h0);
    end
    rstN = 1'b1;
    drive_idle();
    run_cycle("post_reset", CTL_IDLE, 4'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      run_cycle($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_flags);
    end

    // Reset asserted during the second wait cycle clears state and flags at once.
    drive(vecs[3]);
    run_cycle("mid_haz", CTL_HAZ, 4'h3);
    drive_idle();
    run_cycle("mid_wait1", CTL_WAIT, 4'h3);
    rstN = 1'b0;
    #1;
    check("mid_rst_ctl", ctl, CTL_IDLE);
    check("mid_rst_flags", {3'b000, flags}, 7'b0000000);
    stall_left = 0;
    m_flags    = 4'b0000;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    run_cycle("mid_rel0", CTL_IDLE, 4'h0);
    run_cycle("mid_rel1", CTL_IDLE, 4'h0);

    for (int i = 0; i < 1500; i++) begin
      drive_random();
      run_cycle($sformatf("rand%0d", i), model_ctl(), m_flags);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
